// File: rtl/dram_seq_pkg.sv
// Shared types and default timing for the MK4116 bank sequencer.
// Address layout is {row[6:0], col[6:0]}.
package dram_seq_pkg;

  localparam int ROW_W                = 7;
  localparam int ADDR_W               = 14;
  localparam int CNT_W                = 8;
  localparam int DATA_W_DEF           = 8;
  localparam int T_CAS_DEF            = 2;
  localparam int T_PRE_DEF            = 2;
  localparam int REFRESH_INTERVAL_DEF = 109;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RAS,
    CADDR,
    CAS,
    LATCH,
    PRE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    VID,
    REF,
    CPU
  } owner_t;

  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:ROW_W];
  endfunction

  function automatic logic [ROW_W-1:0] col_of(input logic [ADDR_W-1:0] addr);
    return addr[ROW_W-1:0];
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval down-counter and 2-bit saturating count of refreshes owed.
// Built only when DRAM_SEQ_REFRESH_EN is defined.
module dram_refresh_timer
  import dram_seq_pkg::*;
#(
  parameter int INTERVAL = REFRESH_INTERVAL_DEF
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       tick_en,
  input  logic       refresh_done,
  output logic [1:0] pending
);

  localparam int TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  logic [TW-1:0] interval_cnt;
  logic          tick;

  assign tick = tick_en && (interval_cnt == '0);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      interval_cnt <= TW'(INTERVAL - 1);
    end else if (tick_en) begin
      if (interval_cnt == '0) interval_cnt <= TW'(INTERVAL - 1);
      else                    interval_cnt <= interval_cnt - 1'b1;
    end
  end

  // A tick and a completion on the same clock cancel out.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      pending <= 2'd0;
    end else begin
      unique case ({tick, refresh_done})
        2'b10:   if (pending != 2'd3) pending <= pending + 2'd1;
        2'b01:   if (pending != 2'd0) pending <= pending - 2'd1;
        default: pending <= pending;
      endcase
    end
  end

endmodule

// File: rtl/dram_sequencer.sv
// MK4116 bank sequencer: arbitrates video, refresh and CPU, drives RAS/CAS/WE/A.
// Refresh logic is built only when DRAM_SEQ_REFRESH_EN is defined.
//
// state | meaning
// IDLE  | bus idle, arbitration evaluated
// RADDR | row address on A, nRAS high
// RAS   | nRAS low (refresh: T_CAS+3 clks, no CAS)
// CADDR | column on A, nWRITE and Din set up
// CAS   | nCAS low for T_CAS clks
// LATCH | nCAS high, DRAM drives Dout, sampled at end
// PRE   | precharge for T_PRE clks, ack on first clock
module dram_sequencer
  import dram_seq_pkg::*;
#(
  parameter int DATA_W           = DATA_W_DEF,
  parameter int T_CAS            = T_CAS_DEF,
  parameter int T_PRE            = T_PRE_DEF,
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic [ROW_W-1:0]  A,
  output logic              nRAS,
  output logic              nCAS,
  output logic              nWRITE,
  output logic [DATA_W-1:0] Din,
  input  logic [DATA_W-1:0] Dout
);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d, grant;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, grant_addr;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          pending;
  logic [ROW_W-1:0]    ref_row;
  logic                go_pre;

  logic [ROW_W-1:0]    a_d;
  logic                nras_d, ncas_d, nwrite_d;
  logic [DATA_W-1:0]   din_d;
  logic                cpu_ack_d, vid_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_d, vid_rdata_d;

`ifdef DRAM_SEQ_REFRESH_EN
  logic             ref_done;
  logic [ROW_W-1:0] row_q;

  assign ref_done = (state_q == RAS) && (owner_q == REF) && (cnt_q == '0);

  dram_refresh_timer #(
    .INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .CLK         (CLK),
    .nRESET      (nRESET),
    .tick_en     (1'b1),
    .refresh_done(ref_done),
    .pending     (pending)
  );

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)       row_q <= '0;
    else if (ref_done) row_q <= row_q + 1'b1;
  end

  assign ref_row = row_q;
`else
  assign pending = 2'd0;
  assign ref_row = '0;
`endif

  // Overdue refresh beats video; a single owed refresh only beats the CPU.
  always_comb begin
    grant = NONE;
    if (pending >= 2'd2)      grant = REF;
    else if (vid_req)         grant = VID;
    else if (pending == 2'd1) grant = REF;
    else if (cpu_req)         grant = CPU;
  end

  always_comb begin
    grant_addr = cpu_addr;
    unique case (grant)
      VID:     grant_addr = vid_addr;
      REF:     grant_addr = {ref_row, {ROW_W{1'b0}}};
      default: grant_addr = cpu_addr;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      owner_q <= NONE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // Pin values are computed for the state being entered so every strobe is a flop.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    a_d         = A;
    nras_d      = nRAS;
    ncas_d      = nCAS;
    nwrite_d    = nWRITE;
    din_d       = Din;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata;
    vid_rdata_d = vid_rdata;
    go_pre      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant != NONE) begin
          state_d = RADDR;
          owner_d = grant;
          addr_d  = grant_addr;
          we_d    = (grant == CPU) && cpu_we;
          wdata_d = (grant == CPU) ? cpu_wdata : '0;
          a_d     = row_of(grant_addr);
          nras_d  = 1'b1;
        end
      end
      RADDR: begin
        state_d = RAS;
        nras_d  = 1'b0;
        cnt_d   = (owner_q == REF) ? CNT_W'(T_CAS + 2) : '0;
      end
      RAS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (owner_q == REF) begin
          go_pre = 1'b1;
        end else begin
          state_d  = CADDR;
          a_d      = col_of(addr_q);
          nwrite_d = !we_q;
          din_d    = wdata_q;
        end
      end
      CADDR: begin
        state_d = CAS;
        ncas_d  = 1'b0;
        cnt_d   = CNT_W'(T_CAS - 1);
      end
      CAS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = LATCH;
          ncas_d  = 1'b1;
        end
      end
      LATCH: begin
        go_pre = 1'b1;
        if (owner_q == VID) begin
          vid_ack_d   = 1'b1;
          vid_rdata_d = Dout;
        end else if (owner_q == CPU) begin
          cpu_ack_d = 1'b1;
          if (!we_q) cpu_rdata_d = Dout;
        end
      end
      PRE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          owner_d = NONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_pre) begin
      state_d  = PRE;
      nras_d   = 1'b1;
      ncas_d   = 1'b1;
      nwrite_d = 1'b1;
      a_d      = '0;
      cnt_d    = CNT_W'(T_PRE - 1);
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      A         <= '0;
      nRAS      <= 1'b1;
      nCAS      <= 1'b1;
      nWRITE    <= 1'b1;
      Din       <= '0;
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;
      cpu_rdata <= '0;
      vid_rdata <= '0;
    end else begin
      A         <= a_d;
      nRAS      <= nras_d;
      nCAS      <= ncas_d;
      nWRITE    <= nwrite_d;
      Din       <= din_d;
      cpu_ack   <= cpu_ack_d;
      vid_ack   <= vid_ack_d;
      cpu_rdata <= cpu_rdata_d;
      vid_rdata <= vid_rdata_d;
    end
  end

endmodule

// File: doc/dram_sequencer.md
Name: dram_sequencer

Overview:
- Cycle-accurate controller for a bank of MK4116 16K×1 DRAMs, DATA_W chips sharing A/nRAS/nCAS/nWRITE.
- Arbitrates three requesters for the bank: video fetch, internal refresh and CPU.
- Sequences multiplexed row/column addressing, early-write and read cycles, and RAS-only refresh.
- Sits between the ULA video/CPU interfaces and the DRAM array.

Parameters:
- DATA_W, 8, number of 4116 chips in the bank (data bits).
- T_CAS, 2, clocks nCAS is held low (≥1).
- T_PRE, 2, clocks of RAS precharge after each cycle (≥1).
- REFRESH_INTERVAL, 109, clocks between refresh ticks (128 rows per 2 ms at 7 MHz).

Ports:
- CLK in 1: single clock, all logic on rising edge.
- nRESET in 1: asynchronous, active-low reset.
- cpu_req in 1: CPU request level; addr/we/wdata held stable until cpu_ack.
- cpu_we in 1: 1 = write.
- cpu_addr in 14: {row[6:0], col[6:0]}.
- cpu_wdata in DATA_W: write data.
- cpu_ack out 1: one-cycle completion pulse.
- cpu_rdata out DATA_W: read data, valid with cpu_ack, held until the next CPU read.
- vid_req in 1: video read request level.
- vid_addr in 14: video address.
- vid_ack out 1: one-cycle completion pulse.
- vid_rdata out DATA_W: read data, valid with vid_ack.
- A out 7: multiplexed DRAM address.
- nRAS out 1: row strobe.
- nCAS out 1: column strobe.
- nWRITE out 1: write enable, active low.
- Din out DATA_W: data to DRAM.
- Dout in DATA_W: data from DRAM; DRAM updates it on rising nCAS.

Behaviour:
- Reset values (asynchronous, immediate): nRAS=nCAS=nWRITE=1, A=0, Din=0, acks=0, rdata=0, state=IDLE, refresh row=0, pending=0.
- Reset mid-cycle aborts the access; no ack is issued.
- All DRAM-side outputs are registered.
- Arbitration is evaluated in IDLE only:
  - refresh when pending≥2 (overdue);
  - else video;
  - else refresh when pending=1;
  - else CPU.
- The grant edge captures address, we and wdata; a request dropped before grant is ignored.
- State machine, one transition per clock unless a count is given:
  - IDLE: bus idle.
  - RADDR (1 clk): A=row, nRAS=1.
  - RAS (1 clk): nRAS=0. For a refresh grant, RAS lasts T_CAS+3 clks with no CAS, then goes to PRE.
  - CADDR (1 clk): A=col, nWRITE=!we, Din=wdata (early write: nWRITE and Din settle before nCAS falls).
  - CAS (T_CAS clks): nCAS=0.
  - LATCH (1 clk): nCAS=1, nRAS=0; Dout sampled at the end of LATCH.
  - PRE (T_PRE clks): nRAS=1, nCAS=1, nWRITE=1, A=0; then IDLE.
- The requester's ack pulses during the first PRE clock, with rdata registered.
  - Reads: rdata = sampled Dout.
  - Writes: ack only, rdata unchanged.
- Latency:
  - grant edge → ack = T_CAS+4 clocks;
  - minimum access period = T_CAS+T_PRE+5 clocks (IDLE always lasts ≥1 clk).
- Refresh bookkeeping:
  - A refresh tick increments pending, a 2-bit counter saturating at 3.
  - Each completed refresh decrements pending and increments the 7-bit row counter, which wraps 127→0.
  - A tick arriving on the same clock as a completion leaves pending unchanged.
- A simultaneous CPU and video request with pending=0: video wins; CPU waits and is served in the next IDLE with no other request.
- CPU starvation is allowed by design: video is budgeted by the ULA slot schedule.

Optional Feature:
- Macro DRAM_SEQ_REFRESH_EN.
- Defined: refresh timer, pending counter, row counter and RAS-only cycles as above.
- Undefined:
  - no refresh logic is built and pending is constant 0;
  - arbitration is video > CPU;
  - used for simulation with non-decaying DRAM models.

Decomposition:
- Package dram_seq_pkg holds:
  - state enum (IDLE, RADDR, RAS, CADDR, CAS, LATCH, PRE);
  - grant-owner enum (NONE, VID, REF, CPU);
  - default timing constants;
  - ROW_W=7 and ADDR_W=14.
- Sub-module dram_refresh_timer holds the interval counter and the saturating pending counter. It has inputs tick-enable and refresh_done, and outputs pending[1:0]. It is instantiated only under DRAM_SEQ_REFRESH_EN.

Test Plan:
- CPU write then read: write 0xA5 to addr 0x1234, then read 0x1234.
  - Write cycle: A=0x24 at nRAS fall, A=0x34 at nCAS fall, nWRITE=0 before nCAS fall.
  - Read: cpu_rdata=0xA5, cpu_ack 6 clks after grant.
- Contention: cpu_req and vid_req raised together, pending=0.
  - vid_ack fires first.
  - cpu_ack fires exactly 9 clks after vid_ack (T_CAS=2, T_PRE=2).
- Refresh: idle for 3×109 clks.
  - Three RAS-only cycles occur with A=0,1,2 and nCAS never low.
  - After 128×109 clks the row wraps to 0.
- Overdue refresh: hold vid_req continuously across 2 ticks.
  - A RAS-only refresh preempts video once pending=2.
- Reset mid-access: deassert nRESET during CAS.
  - nRAS, nCAS and nWRITE are all 1 in the same timestep; no ack.
  - After release, a new CPU read completes normally.
- Macro off: with DRAM_SEQ_REFRESH_EN undefined, idle for 500 clks → nRAS stays 1 throughout.
